// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: timed multiplexed address/data bus master for the external RTC register bank.
// Optional build macro RTC_BUS_VERIFY_EN: each write is followed by a read-back and sets verify_err.

module rtc_bus_ctrl #(
  parameter int unsigned T_PH  = 10,
  parameter int unsigned T_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
`ifdef RTC_BUS_VERIFY_EN
  output logic       verify_err,
`endif
  output logic       cs_n,
  output logic       ad_n,
  output logic       rd_n,
  output logic       wr_n
);

  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(T_PH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(T_GAP - 1);
`ifdef RTC_BUS_VERIFY_EN
  // Turnaround between write and read-back matches a FIN + IDLE pair
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(1);
`endif

  if (T_PH < 1 || T_GAP < 1 || T_PH > 65536 || T_GAP > 65536) begin : g_bad_timing
    $error("rtc_bus_ctrl: T_PH and T_GAP must be in 1..65536");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_LOW  = 3'd1,
    A_GAP  = 3'd2,
    D_LOW  = 3'd3,
    D_GAP  = 3'd4,
    V_TURN = 3'd5,
    FIN    = 3'd6
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             rw_q, rw_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             rd_mode, rd_mode_d;
  logic [DW-1:0]    rdata_d, ad_out_d;
  logic             busy_d, done_d, ad_oe_d;
  logic             cs_n_d, ad_n_d, rd_n_d, wr_n_d;
`ifdef RTC_BUS_VERIFY_EN
  logic             vpass, vpass_d;
  logic             verify_err_d;
`endif

  // State, counter, captured request and registered bus outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ad_out  <= '0;
      ad_oe   <= 1'b0;
      cs_n    <= 1'b1;
      ad_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
`ifdef RTC_BUS_VERIFY_EN
      vpass      <= 1'b0;
      verify_err <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata   <= rdata_d;
      busy    <= busy_d;
      done    <= done_d;
      ad_out  <= ad_out_d;
      ad_oe   <= ad_oe_d;
      cs_n    <= cs_n_d;
      ad_n    <= ad_n_d;
      rd_n    <= rd_n_d;
      wr_n    <= wr_n_d;
`ifdef RTC_BUS_VERIFY_EN
      vpass      <= vpass_d;
      verify_err <= verify_err_d;
`endif
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_d  = state;
    rdata_d  = rdata;
    ad_out_d = ad_out;
    ad_oe_d  = 1'b0;
    cs_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;

    case (state)
      IDLE:  if (start) state_d = A_LOW;
      A_LOW: if (cnt == PH_LAST) state_d = A_GAP;
      A_GAP: if (cnt == GAP_LAST) state_d = D_LOW;
      D_LOW: if (cnt == PH_LAST) state_d = D_GAP;
      D_GAP: begin
        if (cnt == GAP_LAST) begin
`ifdef RTC_BUS_VERIFY_EN
          state_d = (!rw_q && !vpass) ? V_TURN : FIN;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef RTC_BUS_VERIFY_EN
      V_TURN: if (cnt == TURN_LAST) state_d = A_LOW;
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cnt_d = (state_d != state || state == IDLE) ? '0 : cnt + CNT_W'(1);

    rw_d    = (state == IDLE && start) ? rw    : rw_q;
    addr_d  = (state == IDLE && start) ? addr  : addr_q;
    wdata_d = (state == IDLE && start) ? wdata : wdata_q;

`ifdef RTC_BUS_VERIFY_EN
    vpass_d      = (state_d == V_TURN) ? 1'b1 : (state_d == IDLE) ? 1'b0 : vpass;
    rd_mode      = rw_q | vpass;
    rd_mode_d    = rw_d | vpass_d;
    verify_err_d = verify_err;
    if (state == D_GAP && state_d == FIN && vpass) verify_err_d = (rdata != wdata_q);
`else
    rd_mode   = rw_q;
    rd_mode_d = rw_d;
`endif

    if (state == D_LOW && cnt == PH_LAST && rd_mode) rdata_d = ad_in;

    case (state_d)
      A_LOW: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      A_GAP: begin
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      D_LOW: begin
        cs_n_d = 1'b0;
        if (rd_mode_d) begin
          rd_n_d = 1'b0;
        end else begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE) && (state_d != FIN);
    done_d = (state_d == FIN);
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: randomized bench for rtc_bus_ctrl against a cycle-timeline reference model.
// Honours RTC_BUS_VERIFY_EN to match the DUT build.

module tb_rtc_bus_ctrl;

  localparam int unsigned T_PH  = 10;
  localparam int unsigned T_GAP = 4;
  localparam int unsigned BUS   = 2 * T_PH + 2 * T_GAP;
`ifdef RTC_BUS_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;
  logic       cs_n, ad_n, rd_n, wr_n;
  logic       verr_obs;
`ifdef RTC_BUS_VERIFY_EN
  logic       verify_err;
  assign verr_obs = verify_err;
`else
  assign verr_obs = 1'b0;
`endif

  rtc_bus_ctrl #(.T_PH(T_PH), .T_GAP(T_GAP)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .rw     (rw),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done),
    .ad_out (ad_out),
    .ad_oe  (ad_oe),
    .ad_in  (ad_in),
`ifdef RTC_BUS_VERIFY_EN
    .verify_err (verify_err),
`endif
    .cs_n   (cs_n),
    .ad_n   (ad_n),
    .rd_n   (rd_n),
    .wr_n   (wr_n)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_rdata = 8'h00;
  logic       exp_verr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] rd, input logic [7:0] ao,
                                       input logic cs, input logic adn, input logic rdn,
                                       input logic wrn, input logic oe, input logic bsy,
                                       input logic dn, input logic ve);
    return {8'h00, rd, ao, cs, adn, rdn, wrn, oe, bsy, dn, ve};
  endfunction

  // ad_out is only meaningful while the pad is expected to be driven
  task automatic cmp_cycle(input string tag, input logic [31:0] exp);
    logic [7:0] ao;
    ao = exp[3] ? ad_out : 8'h00;
    check(tag, pack(rdata, ao, cs_n, ad_n, rd_n, wr_n, ad_oe, busy, done, verr_obs), exp);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmp_cycle("idle", pack(exp_rdata, 8'h00, 1, 1, 1, 1, 0, 0, 0, exp_verr));
      start = 1'b0;
      rw    = 1'($urandom);
      addr  = 8'($urandom);
      wdata = 8'($urandom);
      ad_in = 8'($urandom);
    end
  endtask

  // One request: cycle k counts from the cycle after start is sampled in IDLE.
  // rb is the byte the RTC returns on any read pass; abort_k>0 pulls reset in cycle k.
  task automatic run_txn(input logic t_rw, input logic [7:0] t_addr, input logic [7:0] t_wdata,
                         input logic [7:0] rb, input bit b2b, input int abort_k);
    bit verify_wr;
    int last;
    @(negedge clk);
    cmp_cycle("pre_idle", pack(exp_rdata, 8'h00, 1, 1, 1, 1, 0, 0, 0, exp_verr));
    start = 1'b1;
    rw    = t_rw;
    addr  = t_addr;
    wdata = t_wdata;
    ad_in = 8'($urandom);
    verify_wr = VERIFY && !t_rw;
    last = verify_wr ? 2 * BUS + 3 : BUS + 1;
    for (int k = 1; k <= last; k++) begin
      logic cs, adn, rdn, wrn, oe, bsy, dn, rd_last;
      logic [7:0] ao;
      @(negedge clk);
      if (k == abort_k) begin
        start = 1'b0;
        reset = 1'b0;
        #1;
        exp_rdata = 8'h00;
        exp_verr  = 1'b0;
        cmp_cycle("reset_mid", pack(8'h00, 8'h00, 1, 1, 1, 1, 0, 0, 0, 0));
        check("reset_mid_ad_out", {24'h0, ad_out}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        return;
      end
      cs = 1; adn = 1; rdn = 1; wrn = 1; oe = 0; bsy = 1; dn = 0; rd_last = 0; ao = 8'h00;
      if (k == last) begin
        bsy = 0;
        dn  = 1;
        if (verify_wr) exp_verr = (rb != t_wdata);
      end else if (!(verify_wr && k > BUS && k <= BUS + 2)) begin
        int  j;
        bit  rd_pass;
        j       = (k > BUS) ? k - BUS - 2 : k;
        rd_pass = t_rw || (k > BUS);
        if (j <= T_PH) begin
          cs = 0; adn = 0; wrn = 0; oe = 1; ao = t_addr;
        end else if (j <= T_PH + T_GAP) begin
          oe = 1; ao = t_addr;
        end else if (j <= 2 * T_PH + T_GAP) begin
          cs = 0;
          if (rd_pass) begin
            rdn     = 0;
            rd_last = (j == 2 * T_PH + T_GAP);
          end else begin
            wrn = 0; oe = 1; ao = t_wdata;
          end
        end
      end
      cmp_cycle($sformatf("cyc%0d", k), pack(exp_rdata, ao, cs, adn, rdn, wrn, oe, bsy, dn, exp_verr));
      // Stray start pulses while busy must be ignored; start held on FIN for back-to-back
      start = (k == last) ? b2b : ($urandom_range(0, 5) == 0);
      rw    = 1'($urandom);
      addr  = 8'h99;
      wdata = 8'($urandom);
      ad_in = rd_last ? rb : 8'($urandom);
      if (rd_last) exp_rdata = rb;
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    rw    = 1'b0;
    addr  = 8'h00;
    wdata = 8'h00;
    ad_in = 8'h00;
    repeat (2) @(negedge clk);
    cmp_cycle("reset", pack(8'h00, 8'h00, 1, 1, 1, 1, 0, 0, 0, 0));
    check("reset_ad_out", {24'h0, ad_out}, 32'h0);
    reset = 1'b1;
    idle_cycles(2);

    run_txn(1'b0, 8'h21, 8'h59, 8'h59, 1'b0, 0);
    run_txn(1'b1, 8'h22, 8'h00, 8'h37, 1'b0, 0);
    run_txn(1'b0, 8'h10, 8'hAA, 8'hAA, 1'b0, 0);
    idle_cycles(1);
    run_txn(1'b1, 8'h05, 8'h00, 8'hC3, 1'b1, 0);
    run_txn(1'b0, 8'h06, 8'h5A, 8'h5A, 1'b1, 0);
    run_txn(1'b1, 8'h07, 8'h00, 8'h81, 1'b0, 0);
    run_txn(1'b1, 8'h33, 8'h00, 8'h12, 1'b0, 2 * T_PH + T_GAP - 3);
    idle_cycles(3);
    run_txn(1'b0, 8'h30, 8'h45, 8'h44, 1'b0, 0);
    run_txn(1'b0, 8'h30, 8'h45, 8'h45, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      logic       r;
      logic [7:0] a, w, rb;
      r  = 1'($urandom);
      a  = 8'($urandom);
      w  = 8'($urandom);
      if (r) rb = 8'($urandom);
      else   rb = ($urandom_range(0, 2) == 0) ? (w ^ 8'($urandom_range(1, 255))) : w;
      if (n == 25) begin
        run_txn(r, a, w, rb, 1'b0, $urandom_range(1, BUS));
        idle_cycles(2);
      end else begin
        run_txn(r, a, w, rb, 1'($urandom), 0);
        if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
      end
    end
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
